pixel_frame_ctrl: RTL and testbench
===================================

# pixel_frame_ctrl

Frame sequencer and readout controller for the pixel array. Drives the erase/expose/convert/read phases from a runtime exposure setting and generates the digital ADC ramp code driven onto the data buses during conversion. It reads both pixel data buses through a valid/ready output stream. It sits between the pixel array and the downstream frame buffer, replacing the fixed-timing phase FSM.

## Interface
Parameters:
- C_ERASE, 5, erase phase length in cycles (≥1)
- C_CONVERT, 255, convert phase length in cycles (≥1)
- C_READ, 5, bus settle cycles before capture (≥1)
- RAMP_STEP, 257, ramp code increment per convert cycle

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  frame request, sampled only in IDLE
- abort  in  1  synchronous abort, any state
- exp_cycles  in  16  exposure length, sampled on accepted start; 0 treated as 1
- erase, expose, convert, read_1, read_2  out  1  pixel array phase controls
- ramp_code  out  16  ADC ramp value driven on the data buses while not reading
- pix_data_1, pix_data_2  in  16  pixel data buses (valid while matching read_x high)
- out_data  out  16  captured pixel value
- out_sel  out  1  0 = bus 1 sample, 1 = bus 2 sample
- out_valid  out  1  out_data/out_sel valid
- out_ready  in  1  downstream accept
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse on normal frame completion

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → READ1 → READ2 → IDLE.
- IDLE: all controls low. start=1 latches exp_cycles and moves to ERASE next cycle. start outside IDLE is ignored.
- ERASE: erase=1 for C_ERASE cycles.
- EXPOSE: expose=1 for max(exp_cycles,1) cycles.
- CONVERT: convert=1 for C_CONVERT cycles. ramp_code=0 on the first convert cycle, then +RAMP_STEP each cycle, mod 2^16. ramp_code=0 in all other states.
- READ1: read_1=1. After C_READ cycles, pix_data_1 is registered into out_data with out_sel=0 and out_valid=1. read_1 stays high until the handshake (out_valid & out_ready), then the FSM moves to READ2.
- READ2: same as READ1 using read_2 and pix_data_2, with out_sel=1. After the handshake it moves to IDLE with frame_done=1 for that one cycle.
- out_data and out_sel are held stable while out_valid=1 and out_ready=0. Downstream stalls are unbounded.
- At most one phase control is high in any cycle.
- abort=1: next cycle IDLE; all controls, out_valid and ramp_code go to 0; no frame_done. abort takes priority over start and over a handshake in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE.
- With start at cycle 0, exposure E and out_ready tied 1:
  - erase: cycles 1..C_ERASE
  - expose: next E cycles
  - convert: next C_CONVERT cycles
  - READ1 and READ2: each C_READ+1 cycles
  - frame_done: at cycle 1+C_ERASE+E+C_CONVERT+2·(C_READ+1). With defaults and E=255 this is cycle 528.
- A new start is accepted in the cycle frame_done is high (state is IDLE).
- out_valid rises C_READ cycles after read_x rises and falls the cycle after the handshake.
- Phase counters are internal and reload on every state entry.
- Reset mid-frame forces IDLE immediately (asynchronous).

## Configuration
- PIXEL_FRAME_CNT_EN defined:
  - Adds output port frame_count[15:0], reset value 0.
  - Increments in the cycle frame_done is high and wraps 65535→0.
  - Aborted frames do not count.
- PIXEL_FRAME_CNT_EN undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Package pixel_ctrl_pkg holds:
  - the state enum (IDLE, ERASE, EXPOSE, CONVERT, READ1, READ2)
  - default phase-length constants
  - the ramp code width constant
- Sub-module pixel_phase_timer: a 16-bit down-counter with load value, load strobe and a done flag. It is instantiated once and shared by all phases.

## Test plan
- Defaults, exp_cycles=255, out_ready=1, start at cycle 0 → erase 1..5, expose 6..260, convert 261..515, read_1 516..521, read_2 522..527, frame_done at 528.
- During convert → ramp_code = 0, 257, 514, … with a last value of 65278; ramp_code=0 outside convert.
- exp_cycles=0 → exactly one expose cycle; frame_done at 274.
- out_ready=0 for 20 cycles after the READ1 capture, with pix_data_1=0x1234 → out_valid, read_1 and out_data=0x1234 held; READ2 starts the cycle after out_ready rises.
- abort during EXPOSE, and a start pulse during CONVERT → next cycle IDLE with all outputs 0 and no frame_done; the mid-frame start is ignored.
- With PIXEL_FRAME_CNT_EN, three complete frames with one abort between them → frame_count=3; reset asserted mid-READ2 → all outputs 0 immediately.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pixel_ctrl_pkg
// Purpose: Shared types and constants for the pixel frame controller:
//          frame-sequencer state encoding, default phase lengths and the
//          ADC ramp / phase-timer widths.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    READ1   = 3'd4,
    READ2   = 3'd5
  } state_t;

  localparam int C_ERASE_DEF   = 5;
  localparam int C_CONVERT_DEF = 255;
  localparam int C_READ_DEF    = 5;
  localparam int RAMP_STEP_DEF = 257;

  localparam int RAMP_W  = 16;
  localparam int TIMER_W = 16;

endpackage
`default_nettype wire

// File: rtl/pixel_phase_timer.sv
`default_nettype none
// ============================================================================
// Module : pixel_phase_timer
// Purpose: Down-counter shared by all frame phases. A load strobe writes the
//          phase length; the counter then decrements once per cycle and
//          stops at zero. done is high in the last cycle of the phase
//          (count == 1), so the owner can leave the phase on that edge.
// Ports  : clk       - system clock
//          reset     - asynchronous active-high reset
//          load      - load strobe (takes priority over counting)
//          load_val  - phase length in cycles (>= 1)
//          done      - last cycle of the loaded phase
// Rev    : 1.0  initial release
// ============================================================================
module pixel_phase_timer
  import pixel_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == TIMER_W'(1));

endmodule
`default_nettype wire

// File: rtl/pixel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pixel_frame_ctrl
// Purpose: Frame sequencer for the pixel array. Walks IDLE -> ERASE ->
//          EXPOSE -> CONVERT -> READ1 -> READ2 -> IDLE, generates the ADC
//          ramp during CONVERT and hands both pixel bus samples downstream
//          through a valid/ready stream.
// Ports  : clk, reset            - clock, async active-high reset
//          start, exp_cycles     - frame request and exposure length
//          abort                 - synchronous return to IDLE
//          erase/expose/convert/read_1/read_2 - phase controls
//          ramp_code             - ADC ramp value (0 outside CONVERT)
//          pix_data_1/2          - pixel data buses
//          out_data/out_sel/out_valid/out_ready - output sample stream
//          busy, frame_done      - status
//          frame_count           - completed-frame counter (optional)
// Config : define PIXEL_FRAME_CNT_EN to add the frame_count output.
// Rev    : 1.0  initial release
// ============================================================================
module pixel_frame_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int C_ERASE   = C_ERASE_DEF,
  parameter int C_CONVERT = C_CONVERT_DEF,
  parameter int C_READ    = C_READ_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       exp_cycles,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic              read_1,
  output logic              read_2,
  output logic [RAMP_W-1:0] ramp_code,
  input  logic [15:0]       pix_data_1,
  input  logic [15:0]       pix_data_2,
  output logic [15:0]       out_data,
  output logic              out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef PIXEL_FRAME_CNT_EN
  output logic [15:0]       frame_count,
`endif
  output logic              frame_done
);

  state_t              state_q, state_d;
  logic [15:0]         exp_q, exp_d;
  logic [RAMP_W-1:0]   ramp_q, ramp_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_done;

  pixel_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Every state transition reloads the shared timer with the length of the
  // phase being entered, so the timer always counts the current phase.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    ramp_d       = '0;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_d    = (exp_cycles == 16'd0) ? 16'd1 : exp_cycles;
            state_d  = ERASE;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(C_ERASE);
          end
        end
        ERASE: begin
          if (tmr_done) begin
            state_d  = EXPOSE;
            tmr_load = 1'b1;
            tmr_val  = exp_q;
          end
        end
        EXPOSE: begin
          if (tmr_done) begin
            state_d  = CONVERT;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(C_CONVERT);
          end
        end
        CONVERT: begin
          // ramp_q is zero on entry, so the first convert cycle shows 0.
          ramp_d = ramp_q + RAMP_W'(RAMP_STEP);
          if (tmr_done) begin
            ramp_d   = '0;
            state_d  = READ1;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(C_READ);
          end
        end
        READ1, READ2: begin
          if (out_valid_q) begin
            if (out_ready) begin
              out_valid_d = 1'b0;
              if (state_q == READ1) begin
                state_d  = READ2;
                tmr_load = 1'b1;
                tmr_val  = TIMER_W'(C_READ);
              end else begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
              end
            end
          end else if (tmr_done) begin
            // Bus has settled for C_READ cycles: capture on this edge.
            out_valid_d = 1'b1;
            out_sel_d   = (state_q == READ2);
            out_data_d  = (state_q == READ2) ? pix_data_2 : pix_data_1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      ramp_q       <= '0;
      out_data_q   <= '0;
      out_sel_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      ramp_q       <= ramp_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PIXEL_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Counts on the same edge that raises frame_done; wraps naturally.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_done_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign erase      = (state_q == ERASE);
  assign expose     = (state_q == EXPOSE);
  assign convert    = (state_q == CONVERT);
  assign read_1     = (state_q == READ1);
  assign read_2     = (state_q == READ2);
  assign ramp_code  = (state_q == CONVERT) ? ramp_q : '0;
  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;
  assign out_sel    = out_sel_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pixel_frame_ctrl
// Purpose: Self-checking bench for pixel_frame_ctrl. A phase/age model
//          predicts every output each cycle; directed sequences pin the
//          documented frame timing, stall, abort and reset behaviour.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pixel_frame_ctrl;

  localparam int C_ERASE   = 5;
  localparam int C_CONVERT = 255;
  localparam int C_READ    = 5;
  localparam int RAMP_STEP = 257;

  localparam int P_IDLE = 0, P_ERASE = 1, P_EXPOSE = 2, P_CONVERT = 3, P_READ1 = 4, P_READ2 = 5;
  localparam int S_EXPOSE = 0, S_CONVERT = 1, S_READ1 = 2, S_READ2 = 3, S_VALID = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [15:0] exp_cycles = '0, pix_data_1 = '0, pix_data_2 = '0;
  logic        erase, expose, convert, read_1, read_2, out_sel, out_valid, busy, frame_done;
  logic [15:0] ramp_code, out_data;
`ifdef PIXEL_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  pixel_frame_ctrl #(
    .C_ERASE(C_ERASE), .C_CONVERT(C_CONVERT), .C_READ(C_READ), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .exp_cycles(exp_cycles),
    .erase(erase), .expose(expose), .convert(convert), .read_1(read_1), .read_2(read_2),
    .ramp_code(ramp_code), .pix_data_1(pix_data_1), .pix_data_2(pix_data_2),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
`ifdef PIXEL_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: phase + cycles spent in it --------
  int          m_ph = P_IDLE, m_age = 0, m_exp = 1, m_frames = 0;
  bit          m_valid = 0, m_sel = 0, m_fd = 0;
  logic [15:0] m_data = '0;

  task automatic m_go(input int ph);
    m_ph  = ph;
    m_age = 0;
  endtask

  task automatic m_step();
    m_fd = 0;
    if (abort) begin
      m_go(P_IDLE);
      m_valid = 0;
    end else begin
      case (m_ph)
        P_IDLE:    if (start) begin
                     m_exp = (exp_cycles == 0) ? 1 : int'(exp_cycles);
                     m_go(P_ERASE);
                   end
        P_ERASE:   if (m_age == C_ERASE - 1) m_go(P_EXPOSE); else m_age++;
        P_EXPOSE:  if (m_age == m_exp - 1) m_go(P_CONVERT); else m_age++;
        P_CONVERT: if (m_age == C_CONVERT - 1) m_go(P_READ1); else m_age++;
        default: begin
          if (m_valid && out_ready) begin
            m_valid = 0;
            if (m_ph == P_READ1) m_go(P_READ2);
            else begin
              m_go(P_IDLE);
              m_fd     = 1;
              m_frames = (m_frames + 1) % 65536;
            end
          end else begin
            if (!m_valid && m_age == C_READ - 1) begin
              m_valid = 1;
              m_sel   = (m_ph == P_READ2);
              m_data  = m_sel ? pix_data_2 : pix_data_1;
            end
            m_age++;
          end
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_go(P_IDLE);
        m_valid = 0; m_sel = 0; m_fd = 0; m_data = '0; m_frames = 0;
      end else begin
        m_step();
      end
    end
  end

  // ---------------- compare process -------------------------------------
  task automatic compare_all();
    logic [15:0] exp_ramp;
    exp_ramp = (m_ph == P_CONVERT) ? 16'((m_age * RAMP_STEP) % 65536) : 16'd0;
    check("erase",      erase,      m_ph == P_ERASE);
    check("expose",     expose,     m_ph == P_EXPOSE);
    check("convert",    convert,    m_ph == P_CONVERT);
    check("read_1",     read_1,     m_ph == P_READ1);
    check("read_2",     read_2,     m_ph == P_READ2);
    check("busy",       busy,       m_ph != P_IDLE);
    check("ramp_code",  ramp_code,  exp_ramp);
    check("out_valid",  out_valid,  m_valid);
    check("frame_done", frame_done, m_fd);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_sel",  out_sel,  m_sel);
    end
`ifdef PIXEL_FRAME_CNT_EN
    check("frame_count", frame_count, m_frames);
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) compare_all();
    end
  end

  // ---------------- directed helpers ------------------------------------
  function automatic logic sig_of(input int w);
    case (w)
      S_EXPOSE:  return expose;
      S_CONVERT: return convert;
      S_READ1:   return read_1;
      S_READ2:   return read_2;
      default:   return out_valid;
    endcase
  endfunction

  // Leaves the caller at the negedge of the first cycle the signal is high.
  task automatic wait_sig(input string name, input int w, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (sig_of(w)) begin ok = 1; break; end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic start_frame(input logic [15:0] e);
    @(posedge clk); #1;
    start = 1; exp_cycles = e;
    @(posedge clk); #1;
    start = 0;
  endtask

  // Runs one frame with out_ready high; cycle numbers are relative to the
  // start cycle (cycle 0).
  task automatic directed_frame(input logic [15:0] e, input int exp_fd, input bit full);
    int er_f = -1, er_l = -1, ex_f = -1, ex_l = -1, cv_f = -1, cv_l = -1;
    int r1_f = -1, r1_l = -1, r2_f = -1, r2_l = -1, fd_at = -1;
    logic [15:0] ramp0 = '1, ramp1 = '1, ramp_last = '0;
    out_ready = 1;
    start_frame(e);
    for (int rel = 1; rel < 2000 && fd_at < 0; rel++) begin
      @(negedge clk);
      if (erase)  begin if (er_f < 0) er_f = rel; er_l = rel; end
      if (expose) begin if (ex_f < 0) ex_f = rel; ex_l = rel; end
      if (convert) begin
        if (cv_f < 0) begin cv_f = rel; ramp0 = ramp_code; end
        if (rel == cv_f + 1) ramp1 = ramp_code;
        cv_l = rel; ramp_last = ramp_code;
      end
      if (read_1) begin if (r1_f < 0) r1_f = rel; r1_l = rel; end
      if (read_2) begin if (r2_f < 0) r2_f = rel; r2_l = rel; end
      if (frame_done) fd_at = rel;
      @(posedge clk); #1;
    end
    check("frame_done_cycle", fd_at, exp_fd);
    check("expose_len", ex_l - ex_f + 1, (e == 0) ? 1 : int'(e));
    if (full) begin
      check("erase_first", er_f, 1);     check("erase_last", er_l, 5);
      check("expose_first", ex_f, 6);    check("expose_last", ex_l, 260);
      check("convert_first", cv_f, 261); check("convert_last", cv_l, 515);
      check("read1_first", r1_f, 516);   check("read1_last", r1_l, 521);
      check("read2_first", r2_f, 522);   check("read2_last", r2_l, 527);
      check("ramp_first", ramp0, 16'd0); check("ramp_second", ramp1, 16'd257);
      check("ramp_last", ramp_last, 16'd65278);
    end
  endtask

  // ---------------- main sequence ---------------------------------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", out_valid, 1'b0);
    check("reset_ramp", ramp_code, 16'd0);

    // Nominal frame timing, then minimum exposure.
    directed_frame(16'd255, 528, 1'b1);
    directed_frame(16'd0, 274, 1'b0);

    // Downstream stall after the READ1 capture.
    out_ready = 0; pix_data_1 = 16'h1234; pix_data_2 = 16'h5678;
    start_frame(16'd3);
    wait_sig("stall_valid", S_VALID, 600);
    pix_data_1 = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      check("stall_valid_held", out_valid, 1'b1);
      check("stall_read1_held", read_1, 1'b1);
      check("stall_data_held", out_data, 16'h1234);
      @(posedge clk); #1;
      @(negedge clk);
    end
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_read2_start", read_2, 1'b1);
    check("stall_read1_end", read_1, 1'b0);
    check("stall_valid_drop", out_valid, 1'b0);
    wait_sig("stall_read2_valid", S_VALID, 50);
    check("stall_sel2", out_sel, 1'b1);
    check("stall_data2", out_data, 16'h5678);
    repeat (3) @(posedge clk);
    #1;

    // Abort during EXPOSE.
    start_frame(16'd10);
    wait_sig("abort_exp_reach", S_EXPOSE, 50);
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    check("abort_exp_busy", busy, 1'b0);
    check("abort_exp_expose", expose, 1'b0);

    // Start during CONVERT is ignored; abort during CONVERT clears ramp.
    start_frame(16'd2);
    wait_sig("conv_reach", S_CONVERT, 50);
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    check("conv_start_ignored", convert, 1'b1);
    @(posedge clk); #1; abort = 1; start = 1;
    @(posedge clk); #1; abort = 0; start = 0;
    @(negedge clk);
    check("abort_conv_busy", busy, 1'b0);
    check("abort_conv_ramp", ramp_code, 16'd0);

    // Abort in the same cycle as the READ2 handshake: no frame_done.
    start_frame(16'd1);
    wait_sig("abort_r2_reach", S_READ2, 400);
    wait_sig("abort_r2_valid", S_VALID, 20);
    abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    check("abort_r2_done", frame_done, 1'b0);
    check("abort_r2_valid_drop", out_valid, 1'b0);
    check("abort_r2_busy", busy, 1'b0);

    // Asynchronous reset mid-READ2.
    start_frame(16'd1);
    wait_sig("reset_r2_reach", S_READ2, 400);
    #2; reset = 1;
    #1;
    check("async_rst_read2", read_2, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_valid", out_valid, 1'b0);
    @(posedge clk); #1; reset = 0;

`ifdef PIXEL_FRAME_CNT_EN
    directed_frame(16'd2, 275, 1'b0);
    directed_frame(16'd2, 275, 1'b0);
    start_frame(16'd5);
    wait_sig("cnt_abort_reach", S_EXPOSE, 50);
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    directed_frame(16'd2, 275, 1'b0);
    @(negedge clk);
    check("frame_count_3", frame_count, 16'd3);
`endif

    // Randomised traffic against the model.
    for (int c = 0; c < 12000; c++) begin
      @(posedge clk); #1;
      start      = ($urandom % 6) == 0;
      exp_cycles = 16'($urandom_range(0, 40));
      abort      = ($urandom % 500) == 0;
      out_ready  = ($urandom % 4) != 0;
      pix_data_1 = 16'($urandom);
      pix_data_2 = 16'($urandom);
    end
    @(posedge clk); #1;
    start = 0; abort = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
